// File: rtl/ltsm_sb_tx_arbiter.sv
// Round-robin arbiter that funnels LTSM sub-state sideband messages into a single
// sideband TX port, tracking the busy handshake of each message to completion.
module ltsm_sb_tx_arbiter #(
  parameter int SB_MSG_WIDTH = 4,
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_en,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*SB_MSG_WIDTH-1:0] i_req_msg,
  input  logic                            i_SB_Busy,
  output logic [SB_MSG_WIDTH-1:0]         o_encoded_SB_msg,
  output logic                            o_tx_msg_valid,
  output logic [NUM_REQ-1:0]              o_req_ack,
  output logic [2:0]                      o_grant_id,
  output logic                            o_busy,
  output logic                            o_timeout_err
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                  state;
  logic                    busy_d;
  logic                    fall;
  logic [2:0]              rr_ptr;
  logic [2:0]              winner;
  logic                    found;
  logic                    grant;
  logic                    timeout_hit;
  logic                    done;
  logic [SB_MSG_WIDTH-1:0] msg_q;
  logic [CNT_W-1:0]        cnt;

  assign fall = busy_d & ~i_SB_Busy;

  // Scan downward so the requester closest above rr_ptr is the last (winning) match.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = rr_ptr;
    idx    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (i_req_valid[idx]) begin
        found  = 1'b1;
        winner = 3'(idx);
      end
    end
  end

  assign grant       = (state == IDLE) && i_en && found && !i_SB_Busy;
  assign timeout_hit = (state == WAIT_BUSY) && !i_SB_Busy && (cnt == CNT_W'(BUSY_TIMEOUT));
  assign done        = (state == WAIT_DONE) && fall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      busy_d     <= 1'b0;
      rr_ptr     <= '0;
      msg_q      <= '0;
      cnt        <= '0;
      o_grant_id <= '0;
    end else begin
      busy_d <= i_SB_Busy;
      case (state)
        IDLE: begin
          if (grant) begin
            state      <= ISSUE;
            msg_q      <= i_req_msg[winner*SB_MSG_WIDTH +: SB_MSG_WIDTH];
            o_grant_id <= winner;
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
          cnt   <= '0;
        end
        WAIT_BUSY: begin
          if (i_SB_Busy)        state <= WAIT_DONE;
          else if (timeout_hit) state <= IDLE;
          else                  cnt   <= cnt + 1'b1;
        end
        WAIT_DONE: begin
          if (fall) begin
            state  <= IDLE;
            rr_ptr <= (o_grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : o_grant_id + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ack and timeout are decoded in the cycle the handshake resolves, not one later.
  assign o_tx_msg_valid   = (state == ISSUE);
  assign o_busy           = (state != IDLE);
  assign o_encoded_SB_msg = (state == IDLE) ? '0 : msg_q;
  assign o_req_ack        = done ? (NUM_REQ'(1) << o_grant_id) : '0;
  assign o_timeout_err    = timeout_hit;

endmodule

// File: tb/tb_ltsm_sb_tx_arbiter.sv
// Directed bench for ltsm_sb_tx_arbiter: grant, handshake, fairness, timeout, reset, enable.
module tb_ltsm_sb_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  req_valid;
  logic [15:0] req_msg;
  logic        sb_busy;
  logic [3:0]  enc_msg;
  logic        tx_valid;
  logic [3:0]  req_ack;
  logic [2:0]  grant_id;
  logic        arb_busy;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  ltsm_sb_tx_arbiter #(.SB_MSG_WIDTH(4), .NUM_REQ(4), .BUSY_TIMEOUT(16)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_en             (en),
    .i_req_valid      (req_valid),
    .i_req_msg        (req_msg),
    .i_SB_Busy        (sb_busy),
    .o_encoded_SB_msg (enc_msg),
    .o_tx_msg_valid   (tx_valid),
    .o_req_ack        (req_ack),
    .o_grant_id       (grant_id),
    .o_busy           (arb_busy),
    .o_timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b0; sb_busy = 1'b0; req_valid = '0; req_msg = '0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  // Waits for a strobe, then plays a 2-cycle busy pulse and captures the ack on the fall cycle.
  task automatic serve(output logic got, output logic [2:0] gid, output logic [3:0] msg,
                       output logic [3:0] ack, output int waited);
    got = 1'b0; gid = '0; msg = '0; ack = '0; waited = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        got = 1'b1;
        break;
      end
      step();
      waited++;
    end
    if (!got) return;
    gid = grant_id;
    msg = enc_msg;
    step(); sb_busy = 1'b1;
    step();
    step(); sb_busy = 1'b0;
    @(negedge clk);
    ack = req_ack;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; req_valid = 4'hF; req_msg = 16'hFFFF; sb_busy = 1'b0;
    #2;
    n_checks++;
    if ({arb_busy, tx_valid, enc_msg, grant_id, req_ack, timeout_err} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0", {arb_busy, tx_valid, enc_msg, grant_id, req_ack, timeout_err});
    end
    step(); step();
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0 || arb_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: tx_valid %b busy %b required 0 0", tx_valid, arb_busy);
    end
  endtask

  task automatic test_single();
    apply_reset();
    en = 1'b1; req_msg = 16'h0A00; req_valid = 4'b0100; sb_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0 || enc_msg !== 4'h0) begin
      n_fail++;
      $display("FAIL single_idle: tx_valid %b msg %h required 0 0", tx_valid, enc_msg);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1 || enc_msg !== 4'hA || grant_id !== 3'd2 || arb_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_strobe: valid %b msg %h id %0d busy %b required 1 a 2 1", tx_valid, enc_msg, grant_id, arb_busy);
    end
    step();
    req_msg = 16'h0500; req_valid = 4'b0000; sb_busy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0 || enc_msg !== 4'hA) begin
      n_fail++;
      $display("FAIL single_latched: valid %b msg %h required 0 a", tx_valid, enc_msg);
    end
    step(); step();
    @(negedge clk);
    n_checks++;
    if (req_ack !== 4'b0000 || enc_msg !== 4'hA) begin
      n_fail++;
      $display("FAIL single_busy_hold: ack %b msg %h required 0000 a", req_ack, enc_msg);
    end
    step();
    sb_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ack !== 4'b0100 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack: ack %b tmo %b required 0100 0", req_ack, timeout_err);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (req_ack !== 4'b0000 || arb_busy !== 1'b0 || enc_msg !== 4'h0 || grant_id !== 3'd2) begin
      n_fail++;
      $display("FAIL single_after: ack %b busy %b msg %h id %0d required 0000 0 0 2", req_ack, arb_busy, enc_msg, grant_id);
    end
  endtask

  task automatic test_fairness();
    logic got; logic [2:0] gid; logic [3:0] msg; logic [3:0] ack; int waited;
    logic [3:0] exp_ack;
    apply_reset();
    en = 1'b1; req_msg = 16'h8765; req_valid = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      serve(got, gid, msg, ack, waited);
      exp_ack = 4'(1 << (r % 4));
      n_checks++;
      if (got !== 1'b1 || gid !== 3'(r % 4) || msg !== 4'(5 + r % 4) || ack !== exp_ack) begin
        n_fail++;
        $display("FAIL fair_round%0d: got %b id %0d msg %h ack %b required 1 %0d %h %b",
                 r, got, gid, msg, ack, r % 4, 4'(5 + r % 4), exp_ack);
      end
      n_checks++;
      if (waited !== 1) begin
        n_fail++;
        $display("FAIL back_to_back%0d: strobe after %0d idle cycles required 1", r, waited);
      end
    end
  endtask

  task automatic test_timeout();
    logic got; logic [2:0] gid; logic [3:0] msg; logic [3:0] ack; int waited;
    logic early;
    logic seen;
    apply_reset();
    en = 1'b1; req_msg = 16'h8765; req_valid = 4'b0001;
    serve(got, gid, msg, ack, waited);
    n_checks++;
    if (got !== 1'b1 || gid !== 3'd0 || ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL tmo_prime: got %b id %0d ack %b required 1 0 0001", got, gid, ack);
    end
    req_valid = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    n_checks++;
    if (seen !== 1'b1 || grant_id !== 3'd1) begin
      n_fail++;
      $display("FAIL tmo_grant: strobe %b id %0d required 1 1", seen, grant_id);
    end
    early = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      @(negedge clk);
      if (timeout_err) early = 1'b1;
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_early: pulse seen %b required 0", early);
    end
    step();
    req_valid = 4'b1111;
    @(negedge clk);
    n_checks++;
    if (timeout_err !== 1'b1 || req_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL tmo_pulse: tmo %b ack %b required 1 0000", timeout_err, req_ack);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (timeout_err !== 1'b0 || arb_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_release: tmo %b busy %b required 0 0", timeout_err, arb_busy);
    end
    serve(got, gid, msg, ack, waited);
    n_checks++;
    if (got !== 1'b1 || gid !== 3'd1 || ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL tmo_retry: got %b id %0d ack %b required 1 1 0010", got, gid, ack);
    end
  endtask

  task automatic test_busy_at_request();
    logic seen;
    apply_reset();
    en = 1'b1; req_valid = 4'b0001; req_msg = 16'h0003; sb_busy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
      step();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_block: strobe %b required 0", seen);
    end
    sb_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_release_same: strobe %b required 0", tx_valid);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1 || grant_id !== 3'd0 || enc_msg !== 4'h3) begin
      n_fail++;
      $display("FAIL busy_release_next: strobe %b id %0d msg %h required 1 0 3", tx_valid, grant_id, enc_msg);
    end
  endtask

  task automatic test_reset_mid();
    logic got; logic [2:0] gid; logic [3:0] msg; logic [3:0] ack; int waited;
    logic seen;
    apply_reset();
    en = 1'b1; req_msg = 16'h8765; req_valid = 4'b0001;
    serve(got, gid, msg, ack, waited);
    req_valid = 4'b0100;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    step(); sb_busy = 1'b1;
    step(); step();
    @(negedge clk);
    n_checks++;
    if (seen !== 1'b1 || arb_busy !== 1'b1 || grant_id !== 3'd2) begin
      n_fail++;
      $display("FAIL rstmid_setup: strobe %b busy %b id %0d required 1 1 2", seen, arb_busy, grant_id);
    end
    #2;
    rst_n = 1'b0; sb_busy = 1'b0;
    #1;
    n_checks++;
    if ({arb_busy, tx_valid, enc_msg, grant_id, req_ack, timeout_err} !== 14'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b required 0", {arb_busy, tx_valid, enc_msg, grant_id, req_ack, timeout_err});
    end
    step();
    req_valid = 4'b1001;
    rst_n = 1'b1;
    serve(got, gid, msg, ack, waited);
    n_checks++;
    if (got !== 1'b1 || gid !== 3'd0 || ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstmid_restart: got %b id %0d ack %b required 1 0 0001", got, gid, ack);
    end
  endtask

  task automatic test_enable();
    logic seen;
    apply_reset();
    en = 1'b0; req_valid = 4'b0001; req_msg = 16'h0009; sb_busy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
      step();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL en_block: strobe %b required 0", seen);
    end
    en = 1'b1;
    step();
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1 || enc_msg !== 4'h9) begin
      n_fail++;
      $display("FAIL en_grant: strobe %b msg %h required 1 9", tx_valid, enc_msg);
    end
    step(); sb_busy = 1'b1;
    step(); en = 1'b0;
    step(); sb_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL en_drop_ack: ack %b required 0001", req_ack);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL en_no_regrant: strobe %b required 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_msg = '0; sb_busy = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_busy_at_request();
    test_reset_mid();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ltsm_sb_tx_arbiter.md
LTSM_SB_TX_ARBITER -- requirements
Module: ltsm_sb_tx_arbiter

Interface
REQ-001 SHALL have parameter SB_MSG_WIDTH, default 4, width of one encoded SB message.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (LTSM sub-state blocks); legal range 2..8.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 16, max cycles from issue to i_SB_Busy rising.
REQ-004 SHALL have one clock and an asynchronous active-low reset:
  i_clk  input  1  clock
  i_rst_n  input  1  async reset, active low
  i_en  input  1  arbiter enable; 0 blocks new grants
  i_req_valid  input  NUM_REQ  per-requester message pending, level, held until ack
  i_req_msg  input  NUM_REQ*SB_MSG_WIDTH  requester k's message at bits [k*SB_MSG_WIDTH +: SB_MSG_WIDTH]
  i_SB_Busy  input  1  sideband TX busy, 1 = busy
  o_encoded_SB_msg  output  SB_MSG_WIDTH  message to sideband
  o_tx_msg_valid  output  1  one-cycle issue strobe to sideband
  o_req_ack  output  NUM_REQ  one-hot one-cycle pulse: requester's message fully sent
  o_grant_id  output  3  index of the current or most recent winner
  o_busy  output  1  1 whenever FSM is not IDLE
  o_timeout_err  output  1  one-cycle pulse on busy-rise timeout

Function
REQ-005 SHALL register i_SB_Busy into busy_d (reset 0); fall = busy_d & ~i_SB_Busy.
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE; reset state IDLE.
REQ-007 IDLE -> ISSUE when i_en=1, |i_req_valid=1 and i_SB_Busy=0; otherwise stay IDLE.
REQ-008 On IDLE->ISSUE SHALL select winner round-robin: first set bit of i_req_valid scanning upward from rr_ptr, wrapping at NUM_REQ-1 -> 0.
REQ-009 On IDLE->ISSUE SHALL latch the winner's message and index; later changes of i_req_msg/i_req_valid SHALL NOT affect the transaction.
REQ-010 In ISSUE SHALL drive o_tx_msg_valid=1 for exactly one cycle with the latched message, then go to WAIT_BUSY; latency from qualifying request to strobe = 1 cycle.
REQ-011 o_encoded_SB_msg SHALL hold the latched message in ISSUE, WAIT_BUSY and WAIT_DONE, and SHALL be all-zero in IDLE.
REQ-012 WAIT_BUSY -> WAIT_DONE when i_SB_Busy=1.
REQ-013 WAIT_BUSY SHALL count cycles with a counter cleared on entry; when count reaches BUSY_TIMEOUT with i_SB_Busy still 0, SHALL pulse o_timeout_err, return to IDLE, issue no ack, and leave rr_ptr unchanged (same requester retried).
REQ-014 WAIT_DONE -> IDLE on fall; same cycle SHALL pulse o_req_ack[winner] and set rr_ptr = (winner+1) mod NUM_REQ.
REQ-015 If i_SB_Busy rises and falls within WAIT_BUSY before being sampled high, SHALL treat it as not seen; timeout applies.
REQ-016 i_en deasserted in a non-IDLE state SHALL NOT abort the transaction; only new grants are blocked.
REQ-017 A requester dropping i_req_valid after grant SHALL still receive its ack.
REQ-018 Back-to-back: ack cycle returns to IDLE; next grant evaluated the following cycle at the earliest, so consecutive strobes are >= 2 cycles apart after fall.
REQ-019 o_grant_id SHALL update only on grant; o_busy = (state != IDLE).
REQ-020 o_req_ack and o_timeout_err SHALL never be asserted in the same cycle; o_req_ack SHALL be one-hot or zero.

Reset
REQ-021 On i_rst_n=0, asynchronously: state IDLE, rr_ptr 0, latched message 0, counter 0, busy_d 0, o_grant_id 0, all outputs 0.
REQ-022 Reset mid-transaction SHALL drop the transaction with no ack; after release, arbitration restarts from requester 0.

Verification
REQ-023 Single request: i_req_valid=4'b0100, msg2=4'hA, busy 0 -> strobe next cycle with msg 4'hA; busy 1 for 3 cycles then 0 -> o_req_ack=4'b0100 on fall cycle, o_grant_id=2.
REQ-024 Fairness: all four valid continuously, busy pulses after every strobe -> grant order 0,1,2,3,0; each ack exactly once per round.
REQ-025 Timeout: valid[1]=1, i_SB_Busy held 0 -> o_timeout_err pulses 16 cycles after WAIT_BUSY entry, no ack, next grant is requester 1 again.
REQ-026 Busy at request: i_SB_Busy=1 while valid[0]=1 -> no strobe until busy 0; then strobe 1 cycle later.
REQ-027 Reset during WAIT_DONE: assert i_rst_n=0 -> all outputs 0 immediately, no ack; after release with valid=4'b1001 -> requester 0 granted first.
REQ-028 Enable: i_en=0 with requests pending -> no strobe; i_en dropped in WAIT_DONE -> ack still issued on fall.
